cordic_vectoring: RTL

- Iterative vectoring-mode CORDIC: the inverse of the existing rotation-mode sine/cosine generator.
- Takes a signed Cartesian pair (Xin, Yin) and returns its polar form. The angle uses the same 32-bit binary-angle format as the generator (2^32 = 360 deg). The magnitude carries the uncompensated CORDIC gain of ~1.647.
- One micro-rotation per clock, with a start/done handshake.
- Used to recover the phase and amplitude of generator outputs, and for atan2 in downstream DSP.

---
 rtl/cordic_vectoring.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: converts a signed Cartesian pair into a
// 32-bit binary angle (2^32 = 360 deg) and an uncompensated magnitude
// (gain ~1.647). One micro-rotation per clock, start/done handshake.
module cordic_vectoring #(
    parameter int SZ   = 16,
    parameter int ITER = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic signed [SZ-1:0] i_xin,
    input  logic signed [SZ-1:0] i_yin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [31:0]          o_angle,
    output logic [SZ:0]          o_magnitude
);

    // Three guard bits cover -2^(SZ-1) negation plus the ~1.647 gain.
    localparam int XW = SZ + 3;
    localparam logic [4:0] LAST = 5'(ITER - 1);
    localparam logic signed [XW-1:0] MAG_MAX = {2'b00, {(SZ+1){1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ROT, S_DONE} state_t;

    state_t                r_state;
    logic [4:0]            r_cnt;
    logic signed [SZ-1:0]  r_xin;
    logic signed [SZ-1:0]  r_yin;
    logic signed [XW-1:0]  r_x;
    logic signed [XW-1:0]  r_y;
    logic [31:0]           r_z;
    logic                  r_zero;
    logic                  r_busy;
    logic                  r_done;
    logic [31:0]           r_angle;
    logic [SZ:0]           r_mag;

    logic signed [XW-1:0]  w_xe;
    logic signed [XW-1:0]  w_ye;
    logic signed [XW-1:0]  w_px;
    logic signed [XW-1:0]  w_py;
    logic [31:0]           w_pz;
    logic                  w_zero;
    logic signed [XW-1:0]  w_xs;
    logic signed [XW-1:0]  w_ys;
    logic [31:0]           w_atan;
    logic signed [XW-1:0]  w_xn;
    logic signed [XW-1:0]  w_yn;
    logic [31:0]           w_zn;
    logic [SZ:0]           w_mag;
    logic [31:0]           w_ang;

    // atan(2^-i) scaled so that 2^32 is a full turn, rounded to nearest.
    function automatic logic [31:0] f_atan(input logic [4:0] i);
        logic [31:0] v;
        case (i)
            5'd0:    v = 32'h20000000;
            5'd1:    v = 32'h12E4051E;
            5'd2:    v = 32'h09FB385B;
            5'd3:    v = 32'h051111D4;
            5'd4:    v = 32'h028B0D43;
            5'd5:    v = 32'h0145D7E1;
            5'd6:    v = 32'h00A2F61E;
            5'd7:    v = 32'h00517C55;
            5'd8:    v = 32'h0028BE53;
            5'd9:    v = 32'h00145F2F;
            5'd10:   v = 32'h000A2F98;
            5'd11:   v = 32'h000517CC;
            5'd12:   v = 32'h00028BE6;
            5'd13:   v = 32'h000145F3;
            5'd14:   v = 32'h0000A2FA;
            5'd15:   v = 32'h0000517D;
            5'd16:   v = 32'h000028BE;
            5'd17:   v = 32'h0000145F;
            5'd18:   v = 32'h00000A30;
            5'd19:   v = 32'h00000518;
            5'd20:   v = 32'h0000028C;
            5'd21:   v = 32'h00000146;
            5'd22:   v = 32'h000000A3;
            5'd23:   v = 32'h00000051;
            5'd24:   v = 32'h00000029;
            5'd25:   v = 32'h00000014;
            5'd26:   v = 32'h0000000A;
            5'd27:   v = 32'h00000005;
            5'd28:   v = 32'h00000003;
            5'd29:   v = 32'h00000001;
            5'd30:   v = 32'h00000001;
            default: v = 32'h00000000;
        endcase
        return v;
    endfunction

    assign w_xe   = {{3{r_xin[SZ-1]}}, r_xin};
    assign w_ye   = {{3{r_yin[SZ-1]}}, r_yin};
    assign w_zero = (r_xin == '0) && (r_yin == '0);

    // Pre-rotation folds the left half-plane into the right by +/-90 deg.
    always_comb begin
        w_px = w_xe;
        w_py = w_ye;
        w_pz = 32'h0;
        if (r_xin[SZ-1]) begin
            if (!r_yin[SZ-1]) begin
                w_px = w_ye;
                w_py = -w_xe;
                w_pz = 32'h40000000;
            end else begin
                w_px = -w_ye;
                w_py = w_xe;
                w_pz = 32'hC0000000;
            end
        end
    end

    assign w_xs   = r_x >>> r_cnt;
    assign w_ys   = r_y >>> r_cnt;
    assign w_atan = f_atan(r_cnt);

    // One micro-rotation driving y towards zero; z accumulates the angle.
    always_comb begin
        w_xn = r_x;
        w_yn = r_y;
        w_zn = r_z;
        if (!r_y[XW-1]) begin
            w_xn = r_x + w_ys;
            w_yn = r_y - w_xs;
            w_zn = r_z + w_atan;
        end else begin
            w_xn = r_x - w_ys;
            w_yn = r_y + w_xs;
            w_zn = r_z - w_atan;
        end
    end

    // Result shaping: (0,0) has no defined angle so it reports 0; a negative
    // residual x clamps to 0. The upper clamp cannot trigger for legal inputs.
    always_comb begin
        w_ang = r_zero ? 32'h0 : w_zn;
        w_mag = '0;
        if (r_zero || w_xn[XW-1])
            w_mag = '0;
        else if (w_xn > MAG_MAX)
            w_mag = {(SZ+1){1'b1}};
        else
            w_mag = w_xn[SZ:0];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_xin   <= '0;
            r_yin   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_angle <= '0;
            r_mag   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_xin   <= i_xin;
                        r_yin   <= i_yin;
                        r_busy  <= 1'b1;
                        r_state <= S_PRE;
                    end
                end
                S_PRE: begin
                    r_x     <= w_px;
                    r_y     <= w_py;
                    r_z     <= w_pz;
                    r_zero  <= w_zero;
                    r_cnt   <= '0;
                    r_state <= S_ROT;
                end
                S_ROT: begin
                    r_x <= w_xn;
                    r_y <= w_yn;
                    r_z <= w_zn;
                    if (r_cnt == LAST) begin
                        r_angle <= w_ang;
                        r_mag   <= w_mag;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_angle     = r_angle;
    assign o_magnitude = r_mag;

endmodule
